// File: rtl/fwd_mux_ctrl.sv
// EX-stage operand forwarding select and load-use stall controller (optional FWD_STALL_STATS_EN counters).
// Latency: selects registered as the instruction enters EX; stall is combinational. Backpressure: stall holds ID for one cycle.
module fwd_mux_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
`ifdef FWD_STALL_STATS_EN
  output logic [31:0]      stall_count,
  output logic [31:0]      fwd_count,
`endif
  output logic             stall
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_t;

  // The register file writes before it reads, so the WB-stage entry never
  // feeds a select and only EX and MEM are kept.
  stage_t     ex_q, mem_q, ex_nxt, mem_nxt;
  logic [1:0] sel_a_nxt, sel_b_nxt;

  function automatic logic [1:0] pick(input logic valid, input logic used,
                                      input logic [REG_W-1:0] src,
                                      input stage_t ex, input stage_t mem);
    if (!valid || !used) return 2'b00;
    if (src == ZR) return 2'b11;
    if (ex.v && ex.regwrite && ex.rd == src) return 2'b01;
    if (mem.v && mem.regwrite && mem.rd == src) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    stall = 1'b0;
    if (!reset && !flush && id_valid && ex_q.v && ex_q.memread && ex_q.regwrite && ex_q.rd != ZR)
      stall = (id_use_rn && id_rn == ex_q.rd) || (id_use_rm && id_rm == ex_q.rd);
  end

  always_comb begin
    sel_a_nxt = 2'b00;
    sel_b_nxt = 2'b00;
    ex_nxt    = '0;
    mem_nxt   = ex_q;
    if (flush) mem_nxt.v = 1'b0;
    if (!stall && !flush) begin
      sel_a_nxt = pick(id_valid, id_use_rn, id_rn, ex_q, mem_q);
      sel_b_nxt = pick(id_valid, id_use_rm, id_rm, ex_q, mem_q);
      ex_nxt    = '{v: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      fwd_sel_a <= 2'b00;
      fwd_sel_b <= 2'b00;
    end else begin
      ex_q      <= ex_nxt;
      mem_q     <= mem_nxt;
      fwd_sel_a <= sel_a_nxt;
      fwd_sel_b <= sel_b_nxt;
    end
  end

`ifdef FWD_STALL_STATS_EN
  // 01 and 10 are exactly the selects whose bits differ.
  logic fwd_hit;
  assign fwd_hit = (sel_a_nxt[1] ^ sel_a_nxt[0]) | (sel_b_nxt[1] ^ sel_b_nxt[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + 32'd1;
      if (fwd_hit && fwd_count != '1) fwd_count <= fwd_count + 32'd1;
    end
  end
`endif

endmodule
